// File: rtl/alu_sequencer.sv
// alu_sequencer -- two-cycle (fetch/execute) program sequencer that issues
// control/operand pairs to the accumulator ALU from a small loadable
// instruction memory and branches on the flags the ALU returns.
//
// Instruction word (WIDTH+4 bits): [WIDTH+3] br, [WIDTH+2:WIDTH] op3,
// [WIDTH-1:0] imm.  br=0 issues op3/imm to the ALU; br=1 is a branch whose
// condition is op3 (JMP, JC, JZ, JV, JN, NOP, NOP, HALT) and whose target
// is imm[AW-1:0].
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high; program memory is not cleared
//   start        single-cycle run request (honoured in IDLE/DONE only)
//   prog_we      program memory write strobe (honoured in IDLE/DONE only)
//   prog_addr    program memory write address
//   prog_wdata   instruction word to write
//   alu_flags    {carry, zero, overflow, sign} from the ALU
//   alu_ctrl     ALU control code, HOLD unless executing an ALU op
//   alu_operand  ALU data input, 0 unless executing an ALU op
//   busy         high in FETCH/EXEC
//   done         high in DONE
//   timeout      watchdog expiry (always 0 without the watchdog)
//   pc           current program counter
//
// Build option: define ALU_SEQ_WATCHDOG_EN to add a 16-bit executed-
// instruction watchdog that forces DONE with timeout=1 after 65535
// instructions without HALT.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [WIDTH+3:0] prog_wdata,
  input  logic [3:0]       alu_flags,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_operand,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [AW-1:0]    pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] BR_JMP   = 3'd0;
  localparam logic [2:0] BR_JC    = 3'd1;
  localparam logic [2:0] BR_JZ    = 3'd2;
  localparam logic [2:0] BR_JV    = 3'd3;
  localparam logic [2:0] BR_JN    = 3'd4;
  localparam logic [2:0] BR_HALT  = 3'd7;

  state_t             state;
  state_t             state_next;
  logic [AW-1:0]      pc_next;
  logic [WIDTH+3:0]   ir;
  logic [WIDTH+3:0]   mem [2**AW];

  logic               ir_br;
  logic [2:0]         ir_op;
  logic [WIDTH-1:0]   ir_imm;
  logic               is_halt;
  logic               taken;
  logic               idle_or_done;

  assign ir_br   = ir[WIDTH+3];
  assign ir_op   = ir[WIDTH+2:WIDTH];
  assign ir_imm  = ir[WIDTH-1:0];
  assign is_halt = ir_br && (ir_op == BR_HALT);

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign busy         = (state == S_FETCH) || (state == S_EXEC);
  assign done         = (state == S_DONE);

  // Branch condition; codes 5 and 6 are NOPs and HALT is handled separately.
  always_comb begin
    taken = 1'b0;
    case (ir_op)
      BR_JMP:  taken = 1'b1;
      BR_JC:   taken = alu_flags[3];
      BR_JZ:   taken = alu_flags[2];
      BR_JV:   taken = alu_flags[1];
      BR_JN:   taken = alu_flags[0];
      default: taken = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        wd_expire;
  logic        timeout_q;
`endif

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    alu_ctrl    = OP_HOLD;
    alu_operand = '0;
`ifdef ALU_SEQ_WATCHDOG_EN
    wd_expire   = 1'b0;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
        end
      end
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        if (!ir_br) begin
          // The ALU samples this pair on the edge that ends EXEC.
          alu_ctrl    = ir_op;
          alu_operand = ir_imm;
          pc_next     = pc + AW'(1);
          state_next  = S_FETCH;
        end else if (is_halt) begin
          state_next = S_DONE;
        end else begin
          pc_next    = taken ? ir_imm[AW-1:0] : pc + AW'(1);
          state_next = S_FETCH;
        end
`ifdef ALU_SEQ_WATCHDOG_EN
        // This EXEC is the 65535th executed instruction.
        if (!is_halt && (wd_cnt == 16'hFFFE)) begin
          wd_expire  = 1'b1;
          state_next = S_DONE;
          pc_next    = pc;
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == S_FETCH) ir <= mem[pc];
    end
  end

  // Program memory survives reset; writes are locked out while running.
  always_ff @(posedge clk) begin
    if (prog_we && idle_or_done) mem[prog_addr] <= prog_wdata;
  end

`ifdef ALU_SEQ_WATCHDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (idle_or_done && start) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_EXEC) wd_cnt <= wd_cnt + 16'd1;
      if (wd_expire) timeout_q <= 1'b1;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
